// File: rtl/axi4_mem_model_if.sv
// AXI4 memory channel bundle between a master and the axi4_mem_model slave.
interface axi4_mem_model_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 64,
   parameter int ID_BITS   = 4
);
   logic                   ar_valid;
   logic                   ar_ready;
   logic [ADDR_BITS-1:0]   ar_bits_addr;
   logic [ID_BITS-1:0]     ar_bits_id;
   logic [2:0]             ar_bits_size;
   logic [7:0]             ar_bits_len;

   logic                   aw_valid;
   logic                   aw_ready;
   logic [ADDR_BITS-1:0]   aw_bits_addr;
   logic [ID_BITS-1:0]     aw_bits_id;
   logic [2:0]             aw_bits_size;
   logic [7:0]             aw_bits_len;

   logic                   w_valid;
   logic                   w_ready;
   logic [DATA_BITS-1:0]   w_bits_data;
   logic [DATA_BITS/8-1:0] w_bits_strb;
   logic                   w_bits_last;

   logic                   r_valid;
   logic                   r_ready;
   logic [DATA_BITS-1:0]   r_bits_data;
   logic [ID_BITS-1:0]     r_bits_id;
   logic [1:0]             r_bits_resp;
   logic                   r_bits_last;

   logic                   b_valid;
   logic                   b_ready;
   logic [ID_BITS-1:0]     b_bits_id;
   logic [1:0]             b_bits_resp;

   modport slave (
      input  ar_valid, ar_bits_addr, ar_bits_id, ar_bits_size, ar_bits_len,
      input  aw_valid, aw_bits_addr, aw_bits_id, aw_bits_size, aw_bits_len,
      input  w_valid, w_bits_data, w_bits_strb, w_bits_last,
      input  r_ready, b_ready,
      output ar_ready, aw_ready, w_ready,
      output r_valid, r_bits_data, r_bits_id, r_bits_resp, r_bits_last,
      output b_valid, b_bits_id, b_bits_resp
   );

   modport master (
      output ar_valid, ar_bits_addr, ar_bits_id, ar_bits_size, ar_bits_len,
      output aw_valid, aw_bits_addr, aw_bits_id, aw_bits_size, aw_bits_len,
      output w_valid, w_bits_data, w_bits_strb, w_bits_last,
      output r_ready, b_ready,
      input  ar_ready, aw_ready, w_ready,
      input  r_valid, r_bits_data, r_bits_id, r_bits_resp, r_bits_last,
      input  b_valid, b_bits_id, b_bits_resp
   );
endinterface

// File: rtl/axi4_mem_model.sv
// axi4_mem_model: synthesizable AXI4 slave memory backed by an on-chip word
// array. Independent read and write FSMs, one outstanding burst per direction.
// Optional statistics counters are enabled with `define AXI4_MEM_MODEL_STATS_EN.
module axi4_mem_model #(
   parameter int ADDR_BITS    = 32,
   parameter int DATA_BITS    = 64,
   parameter int ID_BITS      = 4,
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic             clock,
   input  logic             reset,
   axi4_mem_model_if.slave  mem
`ifdef AXI4_MEM_MODEL_STATS_EN
   ,
   output logic [31:0]      stat_rd_beats,
   output logic [31:0]      stat_wr_beats,
   output logic [15:0]      stat_err_resps
`endif
);
   localparam int OFF       = $clog2(DATA_BITS / 8);
   localparam int STRB_BITS = DATA_BITS / 8;
   localparam int DEPTH     = 1 << DEPTH_LOG2;
   localparam int LAT_W     = $clog2(READ_LATENCY + 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

   // Out-of-range address wins over a size that is not the full bus width.
   function automatic logic [1:0] decode_resp(input logic [ADDR_BITS-1:0] addr,
                                              input logic [2:0]           size);
      if ((addr >> (OFF + DEPTH_LOG2)) != '0) return RESP_DECERR;
      if (size != 3'(OFF))                    return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   logic [DATA_BITS-1:0] mem_array [DEPTH];

   r_state_t             r_state, r_state_nxt;
   logic [LAT_W-1:0]     r_cnt;
   logic [7:0]           r_beat, r_len;
   logic [ID_BITS-1:0]   r_id;
   logic [1:0]           r_resp;
   idx_t                 r_idx;
   logic [DATA_BITS-1:0] r_data_q;
   logic                 r_fire, r_more;

   w_state_t             w_state, w_state_nxt;
   logic [7:0]           w_cnt, w_len;
   logic [ID_BITS-1:0]   w_id;
   logic [1:0]           w_resp, b_resp;
   logic                 w_over;
   idx_t                 w_idx;
   logic                 w_fire;

   assign r_fire = mem.r_valid && mem.r_ready;
   assign r_more = r_fire && (r_beat != r_len);
   assign w_fire = mem.w_valid && mem.w_ready;

   // Read FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   // Read FSM next state and handshake outputs.
   always_comb begin
      r_state_nxt      = r_state;
      mem.ar_ready     = 1'b0;
      mem.r_valid      = 1'b0;
      mem.r_bits_id    = r_id;
      mem.r_bits_resp  = 2'b00;
      mem.r_bits_last  = 1'b0;
      mem.r_bits_data  = '0;
      case (r_state)
         R_IDLE: begin
            mem.ar_ready = 1'b1;
            if (mem.ar_valid) r_state_nxt = R_WAIT;
         end
         R_WAIT: begin
            if (r_cnt == '0) r_state_nxt = R_BURST;
         end
         R_BURST: begin
            mem.r_valid     = 1'b1;
            mem.r_bits_resp = r_resp;
            mem.r_bits_last = (r_beat == r_len);
            mem.r_bits_data = (r_resp == RESP_OKAY) ? r_data_q : '0;
            if (mem.r_ready && (r_beat == r_len)) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read burst bookkeeping: captured AR payload, latency and beat counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_beat <= '0;
         r_len  <= '0;
         r_id   <= '0;
         r_resp <= RESP_OKAY;
         r_idx  <= '0;
      end else if (r_state == R_IDLE && mem.ar_valid) begin
         r_cnt  <= LAT_W'(READ_LATENCY - 1);
         r_beat <= '0;
         r_len  <= mem.ar_bits_len;
         r_id   <= mem.ar_bits_id;
         r_resp <= decode_resp(mem.ar_bits_addr, mem.ar_bits_size);
         r_idx  <= mem.ar_bits_addr[OFF +: DEPTH_LOG2];
      end else if (r_state == R_WAIT && r_cnt != '0) begin
         r_cnt  <= r_cnt - LAT_W'(1);
      end else if (r_state == R_BURST && r_more) begin
         r_beat <= r_beat + 8'd1;
         r_idx  <= r_idx + idx_t'(1);
      end
   end

   // Synchronous array read: first word at the end of the wait, then prefetch per beat.
   always_ff @(posedge clock) begin
      if (r_state == R_WAIT && r_cnt == '0)
         r_data_q <= mem_array[r_idx];
      else if (r_state == R_BURST && r_more)
         r_data_q <= mem_array[r_idx + idx_t'(1)];
   end

   // Write FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   // Write FSM next state and handshake outputs.
   always_comb begin
      w_state_nxt     = w_state;
      mem.aw_ready    = 1'b0;
      mem.w_ready     = 1'b0;
      mem.b_valid     = 1'b0;
      mem.b_bits_id   = w_id;
      mem.b_bits_resp = b_resp;
      case (w_state)
         W_IDLE: begin
            mem.aw_ready = 1'b1;
            if (mem.aw_valid) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            mem.w_ready = 1'b1;
            if (mem.w_valid && mem.w_bits_last) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            mem.b_valid = 1'b1;
            if (mem.b_ready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write burst bookkeeping; a burst whose w_last disagrees with len ends in SLVERR.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_cnt  <= '0;
         w_len  <= '0;
         w_id   <= '0;
         w_resp <= RESP_OKAY;
         b_resp <= RESP_OKAY;
         w_over <= 1'b0;
         w_idx  <= '0;
      end else if (w_state == W_IDLE && mem.aw_valid) begin
         w_cnt  <= '0;
         w_len  <= mem.aw_bits_len;
         w_id   <= mem.aw_bits_id;
         w_resp <= decode_resp(mem.aw_bits_addr, mem.aw_bits_size);
         w_over <= 1'b0;
         w_idx  <= mem.aw_bits_addr[OFF +: DEPTH_LOG2];
      end else if (w_fire) begin
         w_idx <= w_idx + idx_t'(1);
         if (mem.w_bits_last) begin
            if (w_resp != RESP_OKAY)                b_resp <= w_resp;
            else if (w_over || (w_cnt != w_len))    b_resp <= RESP_SLVERR;
            else                                    b_resp <= RESP_OKAY;
         end else begin
            if (w_cnt == w_len) w_over <= 1'b1;
            w_cnt <= w_cnt + 8'd1;
         end
      end
   end

   // Byte-enabled array write; error bursts leave the array untouched.
   always_ff @(posedge clock) begin
      if (w_fire && w_resp == RESP_OKAY) begin
         for (int i = 0; i < STRB_BITS; i++)
            if (mem.w_bits_strb[i])
               mem_array[w_idx][8*i +: 8] <= mem.w_bits_data[8*i +: 8];
      end
   end

`ifdef AXI4_MEM_MODEL_STATS_EN
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   assign err_inc = 2'((r_fire && mem.r_bits_last && mem.r_bits_resp != RESP_OKAY))
                  + 2'((mem.b_valid && mem.b_ready && mem.b_bits_resp != RESP_OKAY));
   assign err_sum = {1'b0, stat_err_resps} + 17'(err_inc);

   // Saturating traffic and error-response counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_rd_beats  <= '0;
         stat_wr_beats  <= '0;
         stat_err_resps <= '0;
      end else begin
         if (r_fire && !(&stat_rd_beats)) stat_rd_beats <= stat_rd_beats + 32'd1;
         if (w_fire && !(&stat_wr_beats)) stat_wr_beats <= stat_wr_beats + 32'd1;
         stat_err_resps <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end
`endif
endmodule
